// File: rtl/maze_timer_ctrl_if.sv
// Bundle between the keyboard/position logic, the stopwatch datapath and
// the maze timer controller. The master modport is the environment side;
// the slave modport is the controller side.
interface maze_timer_ctrl_if;
    logic        btn_pause;
    logic        key_valid;
    logic [8:0]  last_change;
    logic [4:0]  row;
    logic [4:0]  column;
    logic [23:0] time_bcd;
    logic        count_en;
    logic        clear_pulse;
    logic [1:0]  state;
    logic [23:0] final_bcd;
    logic [23:0] best_bcd;
    logic        best_valid;
    logic        new_record;

    modport master (
        output btn_pause, key_valid, last_change, row, column, time_bcd,
        input  count_en, clear_pulse, state, final_bcd, best_bcd,
               best_valid, new_record
    );

    modport slave (
        input  btn_pause, key_valid, last_change, row, column, time_bcd,
        output count_en, clear_pulse, state, final_bcd, best_bcd,
               best_valid, new_record
    );
endinterface

// File: rtl/maze_timer_ctrl.sv
// Maze stopwatch sequencing controller: decodes movement keys, the pause
// button and the goal position, drives stopwatch enable/clear, latches the
// finish time and keeps the best (lowest) time record.
// Optional macro IDLE_AUTOPAUSE_EN: pause automatically after PAUSE_TIMEOUT
// ticks in RUNNING without a movement key; a later move resumes.
module maze_timer_ctrl #(
    parameter logic [4:0] GOAL_ROW = 5'd23,
    parameter logic [4:0] GOAL_COL = 5'd31
`ifdef IDLE_AUTOPAUSE_EN
    , parameter logic [7:0] PAUSE_TIMEOUT = 8'd50
`endif
) (
    input  logic              clk_10Hz,
    input  logic              rst,
    maze_timer_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_FINISHED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        btn_delay_q;
    logic        count_en_q, count_en_d;
    logic        clear_pulse_q, clear_pulse_d;
    logic [23:0] final_bcd_q, final_bcd_d;
    logic [23:0] best_bcd_q, best_bcd_d;
    logic        best_valid_q, best_valid_d;
    logic        new_record_q, new_record_d;

    logic btn_edge, move, at_goal;
    logic idle_expire;   // RUNNING has gone idle long enough to auto-pause
    logic auto_resume;   // current pause was automatic, so a move resumes
    logic finish_entry;

    assign btn_edge = bus.btn_pause & ~btn_delay_q;
    assign move     = bus.key_valid &
                      ((bus.last_change == 9'h1D) | (bus.last_change == 9'h1C) |
                       (bus.last_change == 9'h1B) | (bus.last_change == 9'h23));
    assign at_goal  = (bus.row == GOAL_ROW) & (bus.column == GOAL_COL);

`ifdef IDLE_AUTOPAUSE_EN
    localparam logic [7:0] IDLE_LAST = PAUSE_TIMEOUT - 8'd1;

    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic       auto_q, auto_d;

    assign idle_expire = (state_q == ST_RUNNING) & ~move & (idle_cnt_q == IDLE_LAST);
    assign auto_resume = auto_q & move;

    // Idle counter runs only across consecutive move-free RUNNING cycles;
    // auto flag remembers whether the pause came from the timeout.
    always_comb begin
        idle_cnt_d = 8'd0;
        auto_d     = 1'b0;
        if (state_q == ST_RUNNING && state_d == ST_RUNNING && !move)
            idle_cnt_d = idle_cnt_q + 8'd1;
        if (state_d == ST_PAUSED)
            auto_d = (state_q == ST_PAUSED) ? auto_q : (idle_expire & ~btn_edge);
    end

    // Idle counter and auto-pause flag registers.
    always_ff @(posedge clk_10Hz or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= 8'd0;
            auto_q     <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            auto_q     <= auto_d;
        end
    end
`else
    assign idle_expire = 1'b0;
    assign auto_resume = 1'b0;
`endif

    // State register and button delay for edge detection.
    always_ff @(posedge clk_10Hz or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            btn_delay_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_delay_q <= bus.btn_pause;
        end
    end

    // Next-state logic; finishing outranks a same-cycle pause press.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (move) state_d = ST_RUNNING;
            ST_RUNNING: begin
                if (move && at_goal)            state_d = ST_FINISHED;
                else if (btn_edge || idle_expire) state_d = ST_PAUSED;
            end
            ST_PAUSED:   if (btn_edge || auto_resume) state_d = ST_RUNNING;
            ST_FINISHED: if (btn_edge) state_d = ST_IDLE;
        endcase
    end

    // Output next-values: record update happens only on the edge into FINISHED;
    // an equal time does not count as a new record.
    always_comb begin
        finish_entry  = (state_q != ST_FINISHED) && (state_d == ST_FINISHED);
        count_en_d    = (state_d == ST_RUNNING);
        clear_pulse_d = (state_q == ST_FINISHED) && btn_edge;
        final_bcd_d   = final_bcd_q;
        best_bcd_d    = best_bcd_q;
        best_valid_d  = best_valid_q;
        new_record_d  = 1'b0;
        if (finish_entry) begin
            final_bcd_d = bus.time_bcd;
            if (!best_valid_q || (bus.time_bcd < best_bcd_q)) begin
                best_bcd_d   = bus.time_bcd;
                best_valid_d = 1'b1;
                new_record_d = 1'b1;
            end
        end
    end

    // Registered outputs; reset erases the best record.
    always_ff @(posedge clk_10Hz or posedge rst) begin
        if (rst) begin
            count_en_q    <= 1'b0;
            clear_pulse_q <= 1'b0;
            final_bcd_q   <= 24'd0;
            best_bcd_q    <= 24'd0;
            best_valid_q  <= 1'b0;
            new_record_q  <= 1'b0;
        end else begin
            count_en_q    <= count_en_d;
            clear_pulse_q <= clear_pulse_d;
            final_bcd_q   <= final_bcd_d;
            best_bcd_q    <= best_bcd_d;
            best_valid_q  <= best_valid_d;
            new_record_q  <= new_record_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.count_en    = count_en_q;
    assign bus.clear_pulse = clear_pulse_q;
    assign bus.final_bcd   = final_bcd_q;
    assign bus.best_bcd    = best_bcd_q;
    assign bus.best_valid  = best_valid_q;
    assign bus.new_record  = new_record_q;

endmodule

// File: tb/tb_maze_timer_ctrl.sv
// Bench for maze_timer_ctrl: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_maze_timer_ctrl;

`ifdef IDLE_AUTOPAUSE_EN
    localparam bit AP = 1'b1;
`else
    localparam bit AP = 1'b0;
`endif
    localparam int TIMEOUT = 50;

    logic clk_10Hz = 1'b0;
    logic rst;
    always #5 clk_10Hz = ~clk_10Hz;

    maze_timer_ctrl_if bus();
    maze_timer_ctrl dut (.clk_10Hz(clk_10Hz), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: game phase, record book and timing counters.
    int          m_state;
    bit          m_prev, m_bv, m_nr, m_clr, m_auto;
    logic [23:0] m_final, m_best;
    int          m_idle;

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_bv = 0; m_nr = 0; m_clr = 0; m_auto = 0;
        m_final = 0; m_best = 0; m_idle = 0;
    endtask

    task automatic model_step(input bit bp, input bit kv, input logic [8:0] lc,
                              input logic [4:0] r, input logic [4:0] c, input logic [23:0] t);
        bit bedge, mv, goal, fin;
        int nxt;
        bedge = bp && !m_prev;
        mv    = kv && (lc == 9'h1D || lc == 9'h1C || lc == 9'h1B || lc == 9'h23);
        goal  = (r == 5'd23) && (c == 5'd31);
        nxt = m_state; m_clr = 0; m_nr = 0; fin = 0;
        case (m_state)
            0: if (mv) nxt = 1;
            1: if (mv && goal) begin nxt = 3; fin = 1; end
               else if (bedge) begin nxt = 2; m_auto = 0; end
               else if (AP && !mv && m_idle == TIMEOUT - 1) begin nxt = 2; m_auto = 1; end
            2: if (bedge || (mv && m_auto)) nxt = 1;
            default: if (bedge) begin nxt = 0; m_clr = 1; end
        endcase
        if (nxt == 1 && m_state == 1 && !mv) m_idle++; else m_idle = 0;
        if (fin) begin
            m_final = t;
            if (!m_bv || t < m_best) begin m_best = t; m_bv = 1; m_nr = 1; end
        end
        m_state = nxt;
        m_prev  = bp;
    endtask

    task automatic check_all();
        chk("state",      bus.state,       m_state[1:0]);
        chk("count_en",   bus.count_en,    (m_state == 1));
        chk("clear",      bus.clear_pulse, m_clr);
        chk("final_bcd",  bus.final_bcd,   m_final);
        chk("best_bcd",   bus.best_bcd,    m_best);
        chk("best_valid", bus.best_valid,  m_bv);
        chk("new_record", bus.new_record,  m_nr);
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge.
    task automatic tick(input bit bp, input bit kv, input logic [8:0] lc,
                        input logic [4:0] r, input logic [4:0] c, input logic [23:0] t);
        bus.btn_pause = bp; bus.key_valid = kv; bus.last_change = lc;
        bus.row = r; bus.column = c; bus.time_bcd = t;
        @(posedge clk_10Hz);
        model_step(bp, kv, lc, r, c, t);
        @(negedge clk_10Hz);
        check_all();
    endtask

    task automatic idle(); tick(0, 0, 9'h000, 5'd0, 5'd0, 24'h0); endtask
    task automatic mv_key(); tick(0, 1, 9'h1D, 5'd0, 5'd0, 24'h0); endtask
    task automatic press(); tick(1, 0, 9'h000, 5'd0, 5'd0, 24'h0); endtask
    task automatic finish_at(input logic [23:0] t); tick(0, 1, 9'h1B, 5'd23, 5'd31, t); endtask

    // Asynchronous reset applied between clock edges.
    task automatic async_reset();
        bus.btn_pause = 0; bus.key_valid = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_state", bus.state, 2'd0);
        chk("rst_bv",    bus.best_valid, 1'b0);
        check_all();
        @(negedge clk_10Hz);
        rst = 1'b0;
    endtask

    initial begin
        bit bp;
        logic [8:0] codes [4];
        codes[0] = 9'h1D; codes[1] = 9'h1C; codes[2] = 9'h1B; codes[3] = 9'h23;
        rst = 1'b1;
        bus.btn_pause = 0; bus.key_valid = 0; bus.last_change = 0;
        bus.row = 0; bus.column = 0; bus.time_bcd = 0;
        model_reset();
        @(negedge clk_10Hz);
        check_all();
        rst = 1'b0;

        // Start on a move
        idle();
        chk("pre_move_cnt", bus.count_en, 1'b0);
        mv_key();
        chk("run_state", bus.state, 2'd1);
        chk("run_cnt", bus.count_en, 1'b1);

        // Held button gives one pause; move while paused is ignored
        repeat (5) press();
        chk("pause_state", bus.state, 2'd2);
        chk("pause_cnt", bus.count_en, 1'b0);
        idle();
        mv_key();
        chk("pause_move", bus.state, 2'd2);
        press();
        chk("resume", bus.state, 2'd1);
        idle();

        // First finish sets the record
        finish_at(24'h012345);
        chk("fin_state", bus.state, 2'd3);
        chk("fin_final", bus.final_bcd, 24'h012345);
        chk("fin_best", bus.best_bcd, 24'h012345);
        chk("fin_nr", bus.new_record, 1'b1);
        idle();
        chk("nr_once", bus.new_record, 1'b0);
        press();
        chk("clr_state", bus.state, 2'd0);
        chk("clr_pulse", bus.clear_pulse, 1'b1);
        idle();
        chk("clr_once", bus.clear_pulse, 1'b0);
        chk("final_kept", bus.final_bcd, 24'h012345);

        // Slower, faster and equal runs
        mv_key(); finish_at(24'h020000);
        chk("slow_best", bus.best_bcd, 24'h012345);
        chk("slow_nr", bus.new_record, 1'b0);
        press(); idle();
        mv_key(); finish_at(24'h005959);
        chk("fast_best", bus.best_bcd, 24'h005959);
        chk("fast_nr", bus.new_record, 1'b1);
        press(); idle();
        mv_key(); finish_at(24'h005959);
        chk("eq_nr", bus.new_record, 1'b0);
        press(); idle();

        // Button and goal move in the same cycle: finish wins
        mv_key(); idle();
        tick(1, 1, 9'h23, 5'd23, 5'd31, 24'h004000);
        chk("both_state", bus.state, 2'd3);
        chk("both_best", bus.best_bcd, 24'h004000);
        async_reset();

        // Long idle while running
        idle(); mv_key();
        repeat (TIMEOUT) idle();
        chk("idle_state", bus.state, AP ? 2'd2 : 2'd1);
        mv_key();
        chk("idle_resume", bus.state, 2'd1);
        idle();

        // Randomized traffic; low-key phases let the idle timeout fire
        bp = 0;
        for (int i = 0; i < 4000; i++) begin
            bit kv;
            logic [8:0] lc;
            logic [4:0] r, c;
            bit sparse;
            sparse = ((i / 500) % 2) == 1;
            if ($urandom_range(0, 9) < 2) bp = ~bp;
            kv = sparse ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 2) == 0);
            lc = ($urandom_range(0, 9) < 6) ? codes[$urandom_range(0, 3)] : 9'($urandom);
            if ($urandom_range(0, 3) == 0) begin r = 5'd23; c = 5'd31; end
            else begin r = 5'($urandom); c = 5'($urandom); end
            tick(bp, kv, lc, r, c, 24'($urandom));
            if ($urandom_range(0, 699) == 0) begin
                async_reset();
                bp = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
